row_compactor: RTL
==================

Name: row_compactor

Overview:
- Parametrised successor of the single-row clear engine: in one bottom-to-top pass it detects every full row, removes it and compacts all surviving rows downward by the number of full rows found below them.
- Fills the vacated top rows with empty cells and reports the cleared-row count.
- Sits between the game-control FSM (start/done handshake) and the board RAM port, which has RD_LAT-cycle read latency.
- Cell address = y*COLS + x; row 0 is the top row; a cell equal to zero is empty.

Parameters:
COLS, 10, cells per row
ROWS, 24, rows on the board
DATA_W, 6, cell width (colour code, 0 = empty)
ADDR_W, 8, RAM address width; ROWS*COLS <= 2^ADDR_W is required
CNT_W, 5, rows_cleared width; 2^CNT_W > ROWS is required
RD_LAT, 2, RAM read latency in cycles (>= 1)
EARLY_EXIT, 1, 1 = stop scanning at the first fully empty surviving row

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin a compaction pass; sampled only in IDLE
ram_q  in  DATA_W  RAM read data, valid RD_LAT cycles after ram_addr
ram_addr  out  ADDR_W  RAM address
ram_data  out  DATA_W  RAM write data
ram_wren  out  1  RAM write enable, single-cycle pulses
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse at the end of a pass
rows_cleared  out  CNT_W  full rows removed in the last pass; held until the next start

Behaviour:
- Reset (async): state IDLE; ram_addr, ram_data, ram_wren, busy, done, rows_cleared all 0; internal rd_y, wr_y, drop and x also 0.
- Registers: rd_y (source row), wr_y (destination row), drop (full rows found so far), x.
- IDLE: on start, set rd_y = wr_y = ROWS-1, drop = 0, rows_cleared = 0, busy = 1, then go to SCAN.
- SCAN: issue addresses rd_y*COLS + 0 .. COLS-1 on consecutive cycles, ram_wren = 0. Accumulate any_empty and all_empty from ram_q as results return RD_LAT cycles later. The state lasts exactly COLS+RD_LAT cycles.
- Decision after SCAN:
  - Row full: drop++, rd_y-- (wr_y unchanged).
  - Row not full, EARLY_EXIT=1 and row all empty: go to FILL.
  - Row not full and drop == 0: rd_y-- and wr_y-- with no RAM writes.
  - Row not full and drop > 0: go to COPY.
  - If the row just processed was rd_y == 0, go to FILL instead of SCAN. Check this before decrementing; rd_y never wraps.
- COPY: for each x, drive the read address rd_y*COLS+x, wait RD_LAT cycles, then for one cycle drive ram_addr = wr_y*COLS+x, ram_data = ram_q, ram_wren = 1. This takes RD_LAT+1 cycles per cell. After x = COLS-1: rd_y--, wr_y--, back to SCAN (or FILL if rd_y was 0).
- FILL: write 0 to every cell of rows 0..wr_y, one cell per cycle, in descending address order.
  - Skip FILL entirely if drop == 0.
  - With EARLY_EXIT, rows above the empty row are already empty by invariant. FILL still clears rows max(0, wr_y-drop+1)..wr_y only, so drop*COLS writes.
- DONE: rows_cleared = drop, done = 1 for one cycle, busy = 0, back to IDLE.
- start while busy is ignored.
- done and start in the same cycle: start is not accepted until the IDLE cycle.
- Address arithmetic is done in ADDR_W bits with no wrap. drop saturates at ROWS and never overflows CNT_W.
- ram_wren is never high in SCAN, IDLE or DONE. ram_data = 0 whenever ram_wren = 0.
- Reset during COPY or FILL aborts immediately with no further writes. Board contents may be partially shifted; no recovery is attempted.

Test Plan:
- Empty board (all 0), start → EARLY_EXIT stops after row 23; no ram_wren pulses; done after 12+ cycles; rows_cleared = 0.
- Row 23 full, row 22 has a single cell 5 at x=3, rest empty → cell 5 written to addr 233, then FILL clears row 22 (addrs 229..220 = 0); rows_cleared = 1.
- Rows 23, 21, 20 full, rows 22 and 19 partial with distinct colours → row 22 moves to row 23, row 19 moves to row 22, rows 19..21 are zeroed; rows_cleared = 3.
- All 24 rows full (EARLY_EXIT irrelevant) → drop reaches 24, rd_y stops at 0 with no wrap, all 240 cells zeroed, rows_cleared = 24 with no CNT_W overflow.
- Pulse start again mid-pass, then assert reset during COPY → second start ignored; after reset, ram_wren = 0 combinationally, busy = 0, rows_cleared = 0, state IDLE.
- Parameter sweep COLS=12, ROWS=20, RD_LAT=1, EARLY_EXIT=0 → two full rows at the bottom are removed, every row is scanned, written addresses are correct, rows_cleared = 2.

Source files
------------

// File: rtl/row_compactor.sv
// Multi-row clear engine: one bottom-to-top pass removes every full row,
// shifts surviving rows down over the gaps and zero-fills the vacated top rows.
module row_compactor #(
  parameter int COLS       = 10,
  parameter int ROWS       = 24,
  parameter int DATA_W     = 6,
  parameter int ADDR_W     = 8,
  parameter int CNT_W      = 5,
  parameter int RD_LAT     = 2,
  parameter int EARLY_EXIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  rows_cleared
);

  localparam int X_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int Y_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int C_W = $clog2(COLS + RD_LAT + 1);

  localparam logic [Y_W-1:0]   Y_TOP     = Y_W'(ROWS - 1);
  localparam logic [X_W-1:0]   X_LAST    = X_W'(COLS - 1);
  localparam logic [C_W-1:0]   SCAN_LAST = C_W'(COLS + RD_LAT - 1);
  localparam logic [C_W-1:0]   SCAN_END  = C_W'(COLS);
  localparam logic [C_W-1:0]   LAT       = C_W'(RD_LAT);
  localparam logic [CNT_W-1:0] DROP_MAX  = CNT_W'(ROWS);

  typedef enum logic [2:0] {IDLE, SCAN, COPY, FILL, DONE} state_t;

  state_t            state, state_d;
  logic [Y_W-1:0]    rd_y, rd_y_d, wr_y, wr_y_d;
  logic [CNT_W-1:0]  drop, drop_d, fill_left, fill_left_d, rows_cleared_d;
  logic [X_W-1:0]    x, x_d;
  logic [C_W-1:0]    cnt, cnt_d;
  logic              any_empty, any_empty_d, all_empty, all_empty_d;
  logic              q_empty, row_full, row_blank, goto_fill;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [Y_W-1:0] y,
                                                  input logic [ADDR_W-1:0] col);
    return ADDR_W'(y) * ADDR_W'(COLS) + col;
  endfunction

  assign q_empty   = (ram_q == '0);
  assign row_full  = !(any_empty | q_empty);
  assign row_blank = all_empty & q_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rd_y         <= '0;
      wr_y         <= '0;
      drop         <= '0;
      x            <= '0;
      cnt          <= '0;
      any_empty    <= 1'b0;
      all_empty    <= 1'b1;
      fill_left    <= '0;
      rows_cleared <= '0;
    end else begin
      state        <= state_d;
      rd_y         <= rd_y_d;
      wr_y         <= wr_y_d;
      drop         <= drop_d;
      x            <= x_d;
      cnt          <= cnt_d;
      any_empty    <= any_empty_d;
      all_empty    <= all_empty_d;
      fill_left    <= fill_left_d;
      rows_cleared <= rows_cleared_d;
    end
  end

  always_comb begin
    state_d        = state;
    rd_y_d         = rd_y;
    wr_y_d         = wr_y;
    drop_d         = drop;
    x_d            = x;
    cnt_d          = cnt;
    any_empty_d    = any_empty;
    all_empty_d    = all_empty;
    fill_left_d    = fill_left;
    rows_cleared_d = rows_cleared;
    goto_fill      = 1'b0;
    ram_addr       = '0;
    ram_data       = '0;
    ram_wren       = 1'b0;
    busy           = state inside {SCAN, COPY, FILL};
    done           = (state == DONE);

    case (state)
      IDLE: begin
        if (start) begin
          state_d        = SCAN;
          rd_y_d         = Y_TOP;
          wr_y_d         = Y_TOP;
          drop_d         = '0;
          rows_cleared_d = '0;
          cnt_d          = '0;
          any_empty_d    = 1'b0;
          all_empty_d    = 1'b1;
        end
      end

      SCAN: begin
        if (cnt < SCAN_END) ram_addr = cell_addr(rd_y, ADDR_W'(cnt));
        cnt_d = cnt + 1'b1;
        if (cnt >= LAT) begin
          any_empty_d = any_empty | q_empty;
          all_empty_d = all_empty & q_empty;
        end
        // Decision uses the final column's data directly, so it lands in the last SCAN cycle
        if (cnt == SCAN_LAST) begin
          cnt_d       = '0;
          any_empty_d = 1'b0;
          all_empty_d = 1'b1;
          if (row_full) begin
            drop_d = (drop == DROP_MAX) ? drop : drop + 1'b1;
            if (rd_y == '0) goto_fill = 1'b1;
            else            rd_y_d    = rd_y - 1'b1;
          end else if ((EARLY_EXIT != 0) && row_blank) begin
            goto_fill = 1'b1;
          end else if (drop == '0) begin
            if (rd_y == '0) begin
              goto_fill = 1'b1;
            end else begin
              rd_y_d = rd_y - 1'b1;
              wr_y_d = wr_y - 1'b1;
            end
          end else begin
            state_d = COPY;
            x_d     = '0;
          end
        end
      end

      COPY: begin
        if (cnt == LAT) begin
          ram_addr = cell_addr(wr_y, ADDR_W'(x));
          ram_data = ram_q;
          ram_wren = 1'b1;
          cnt_d    = '0;
          if (x == X_LAST) begin
            wr_y_d = wr_y - 1'b1;
            if (rd_y == '0) begin
              goto_fill = 1'b1;
            end else begin
              rd_y_d  = rd_y - 1'b1;
              state_d = SCAN;
            end
          end else begin
            x_d = x + 1'b1;
          end
        end else begin
          ram_addr = cell_addr(rd_y, ADDR_W'(x));
          cnt_d    = cnt + 1'b1;
        end
      end

      FILL: begin
        ram_addr = cell_addr(wr_y, ADDR_W'(x));
        ram_wren = 1'b1;
        if (x == '0) begin
          if (fill_left == CNT_W'(1)) begin
            state_d = DONE;
          end else begin
            fill_left_d = fill_left - 1'b1;
            wr_y_d      = wr_y - 1'b1;
            x_d         = X_LAST;
          end
        end else begin
          x_d = x - 1'b1;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    // Only the drop rows just above the compacted stack need clearing; rows higher up are already empty
    if (goto_fill) begin
      x_d         = X_LAST;
      fill_left_d = drop_d;
      state_d     = (drop_d == '0) ? DONE : FILL;
    end

    if (state_d == DONE) rows_cleared_d = drop_d;
  end

endmodule
